// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two requesters, their result consumer and addsub_arbiter.
// The master side is the requesters plus consumer; the slave side is the arbiter itself.
interface addsub_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin time-sharing of one ripple-carry adder between two ADD/SUB/NEG/PASS requesters.
// Define ADDSUB_SAT_EN to saturate rsp_sum to the signed limit on overflow (default: wrap).

module addsub_arbiter_rca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    logic carry;
    logic carry_msb;

    // NOTE: every variable written in always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        carry     = cin_i;
        carry_msb = 1'b0;
        sum_o     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) carry_msb = carry;
            sum_o[i] = x_i[i] ^ y_i[i] ^ carry;
            carry    = (x_i[i] & y_i[i]) | (carry & (x_i[i] ^ y_i[i]));
        end
        cout_o = carry;
        ovf_o  = carry_msb ^ carry;
    end
endmodule

module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             any_req;
    logic             grant_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] exec_sum;

    // prio_q names the requester that wins when both are valid.
    assign any_req = |bus.req_valid;

    always_comb begin
        grant_id = 1'b0;
        unique case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = prio_q;
            default: grant_id = 1'b0;
        endcase
    end

    assign sel_op = grant_id ? bus.req_op1 : bus.req_op0;
    assign sel_a  = grant_id ? bus.req_a1  : bus.req_a0;
    assign sel_b  = grant_id ? bus.req_b1  : bus.req_b0;

    // Gated by rst_n so the accept strobe is also 0 while reset is held.
    assign bus.req_ready = (rst_n && state_q == ST_IDLE && any_req)
                         ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        add_x   = a_q;
        add_y   = '0;
        add_cin = 1'b0;
        unique case (op_q)
            OP_ADD:  begin add_x = a_q;  add_y = b_q;  add_cin = 1'b0; end
            OP_SUB:  begin add_x = a_q;  add_y = ~b_q; add_cin = 1'b1; end
            OP_NEG:  begin add_x = ~a_q; add_y = '0;   add_cin = 1'b1; end
            OP_PASS: begin add_x = a_q;  add_y = '0;   add_cin = 1'b0; end
            default: begin add_x = a_q;  add_y = '0;   add_cin = 1'b0; end
        endcase
    end

    addsub_arbiter_rca #(.WIDTH(WIDTH)) u_rca (
        .x_i    (add_x),
        .y_i    (add_y),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

`ifdef ADDSUB_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    assign exec_sum = add_ovf ? (add_sum[WIDTH-1] ? SAT_POS : SAT_NEG) : add_sum;
`else
    assign exec_sum = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_EXEC;
                    prio_d  = ~grant_id;
                    op_d    = op_e'(sel_op);
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = grant_id;
                end
            end
            ST_EXEC: begin
                sum_d   = exec_sum;
                cout_d  = add_cout;
                ovf_d   = add_ovf;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: datapath registers are reset too, because the response outputs must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ovf   = ovf_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        (|bus.req_ready) |-> (state_q == ST_IDLE));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable({bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf})));
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: transaction-level model checked every cycle,
// plus hand-computed literal expectations for the listed scenarios.
module tb_addsub_arbiter;
    localparam int W    = 8;
    localparam int UMAX = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    addsub_arbiter_if #(.WIDTH(W)) bus ();

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result straight from the arithmetic meaning of each operation.
    function automatic res_t model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   sa, sb, ua, ub, t, u;
        res_t r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        case (op)
            OP_ADD:  begin t = sa + sb; u = ua + ub; r.cout = (u > UMAX); end
            OP_SUB:  begin t = sa - sb; u = ua - ub; r.cout = (ua >= ub); end
            OP_NEG:  begin t = -sa;     u = -ua;     r.cout = (ua == 0);  end
            default: begin t = sa;      u = ua;      r.cout = 1'b0;       end
        endcase
        r.ovf = (t > SMAX) || (t < SMIN);
        r.sum = W'(u);
        if (SAT && r.ovf) r.sum = (t > 0) ? W'(SMAX) : W'(SMIN);
        return r;
    endfunction

    // Transaction model: free/busy, cycles since accept, priority holder, pending result.
    bit   m_busy = 1'b0;
    int   m_age = 0;
    int   m_prio = 0;
    int   m_id = 0;
    res_t m_res;

    always @(negedge clk) begin : p_model
        logic [1:0] exp_ready;
        int         g;
        if (!rst_n) begin
            check("rst_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout,
                                  bus.rsp_ovf, bus.rsp_sum}, 32'd0);
            m_busy = 1'b0;
            m_age  = 0;
            m_prio = 0;
        end else begin
            exp_ready = 2'b00;
            g = -1;
            if (!m_busy && (bus.req_valid != 2'b00)) begin
                if (bus.req_valid == 2'b11) g = m_prio;
                else g = bus.req_valid[0] ? 0 : 1;
                exp_ready[g] = 1'b1;
            end
            check("model_req_ready", bus.req_ready, exp_ready);
            check("model_rsp_valid", bus.rsp_valid, (m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                check("model_rsp_id", bus.rsp_id, m_id);
                check("model_rsp_sum", bus.rsp_sum, m_res.sum);
                check("model_rsp_cout", bus.rsp_cout, m_res.cout);
                check("model_rsp_ovf", bus.rsp_ovf, m_res.ovf);
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_prio = 1 - g;
                m_id   = g;
                m_res  = (g == 0) ? model_op(bus.req_op0, bus.req_a0, bus.req_b0)
                                  : model_op(bus.req_op1, bus.req_a1, bus.req_b1);
            end else if (m_busy) begin
                if (m_age >= 2) begin
                    if (bus.rsp_ready) m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
        bus.req_valid[id] = v;
    endtask

    task automatic wait_grant(input int id, input string nm);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_grant"}, bus.req_ready, (id == 0) ? 2'b01 : 2'b10);
    endtask

    task automatic run_op(input int id, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string nm);
        set_req(id, 1'b1, op, a, b);
        wait_grant(id, nm);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        @(negedge clk);
        check({nm, "_exec_no_rsp"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        check({nm, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        check({nm, "_rsp_id"}, bus.rsp_id, id);
        check({nm, "_sum"}, bus.rsp_sum, es);
        check({nm, "_cout"}, bus.rsp_cout, ec);
        check({nm, "_ovf"}, bus.rsp_ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : p_stim
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};
        int n;

        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b0, OP_ADD, '0, '0);
        set_req(1, 1'b0, OP_ADD, '0, '0);

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_req_ready", bus.req_ready, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op(0, OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, "t1_add");
        run_op(1, OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, "t2_sub");
        run_op(1, OP_NEG, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, "t2_neg");
        run_op(0, OP_SUB, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, "sub_cout");
        run_op(0, OP_NEG, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, "neg_zero");
        run_op(1, OP_PASS, 8'h5A, 8'hC3, 8'h5A, 1'b0, 1'b0, "pass");
        run_op(0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_wrap");
        run_op(0, OP_ADD, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "t4_add_ovf");
        run_op(1, OP_NEG, 8'h80, 8'h00, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "t4_neg_min");
        run_op(0, OP_SUB, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, "sub_ovf");

        // Both requesters held valid from reset.
        do_reset();
        set_req(0, 1'b1, OP_ADD, 8'h10, 8'h20);
        set_req(1, 1'b1, OP_SUB, 8'h50, 8'h08);
        n = 0;
        while (order.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.req_ready == 2'b01) order.push_back(0);
            else if (bus.req_ready == 2'b10) order.push_back(1);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        check("t3_grant_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t3_grant_order", (i < order.size()) ? order[i] : 99, exp_order[i]);
        repeat (3) @(posedge clk);
        #1;

        // Consumer stall while the other requester waits.
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 8'h11, 8'h22);
        wait_grant(0, "t5");
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, OP_PASS, 8'h3C, 8'h00);
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_rsp_seen", bus.rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", bus.rsp_valid, 1'b1);
            check("t5_hold_sum", bus.rsp_sum, 8'h33);
            check("t5_hold_id", bus.rsp_id, 1'b0);
            check("t5_ready_blocked", bus.req_ready, 2'b00);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_still_valid", bus.rsp_valid, 1'b1);
        @(negedge clk);
        check("t5_released", bus.rsp_valid, 1'b0);
        check("t5_next_grant", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during EXEC after a grant to requester 0.
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02);
        wait_grant(0, "t6");
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        #2 rst_n = 1'b0;
        set_req(0, 1'b1, OP_ADD, 8'h04, 8'h04);
        set_req(1, 1'b1, OP_ADD, 8'h06, 8'h06);
        @(negedge clk);
        check("t6_rst_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_sum}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_rsp", bus.rsp_valid, 1'b0);
        check("t6_first_grant", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
